// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU back-end blocks.
//   ROB_ID_W     - ROB tag width (matches the ROB's ROB_SIZE_WIDTH)
//   DATA_W       - datapath width
//   SRC_ALU/LSB  - CDB source encodings carried on cdb_src
//   cdb_entry_t  - one buffered result, {rob_id, value}
package cpu_pkg;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: small circular FIFO holding completed results for one CDB source.
//   clk, rst      - clock, synchronous active-high reset
//   push, wr_data - write wr_data at the tail (ignored when full)
//   pop           - drop the head entry (ignored when empty)
//   flush         - empty the FIFO; overrides push and pop
//   full, empty   - occupancy flags from the registered count
//   head          - entry at the read pointer, valid whenever !empty
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic do_push;
  logic do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Head is read combinationally so an entry written at one edge can be
  // broadcast in the very next cycle.
  assign head = mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// ALU and LSB results are buffered in one cdb_fifo each; one head per cycle
// is broadcast to the ROB and reservation stations. clear flushes both FIFOs.
//   clk, rst, rdy, clear            - clock, sync reset, global enable, flush
//   alu_valid/rob_id/value, ready   - ALU result handshake
//   lsb_valid/rob_id/value, ready   - LSB result handshake
//   cdb_valid/rob_id/value/src      - broadcast bus (zeroed when not valid)
module cdb_arbiter #(
  parameter int ROB_ID_W   = cpu_pkg::ROB_ID_W,
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
);
  import cpu_pkg::*;

  localparam int ENTRY_W = ROB_ID_W + DATA_W;

  // Index 0 is the ALU source, index 1 the LSB source (matches SRC_*).
  logic [ENTRY_W-1:0] in_data   [2];
  logic [ENTRY_W-1:0] head_data [2];
  logic [1:0]         in_valid;
  logic [1:0]         src_ready;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         full;
  logic [1:0]         empty;

  logic accept_ok;
  logic flush;
  logic grant;
  logic last_grant_reg, last_grant_next;
  logic [ENTRY_W-1:0] grant_entry;

  assign in_valid   = {lsb_valid, alu_valid};
  assign in_data[0] = {alu_rob_id, alu_value};
  assign in_data[1] = {lsb_rob_id, lsb_value};

  // Ready looks only at the registered count, so a same-cycle pop never
  // lets a full FIFO accept.
  assign accept_ok = rdy && !clear && !rst;
  assign flush     = rdy && clear;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_ready[gi] = accept_ok && !full[gi];
      assign push[gi]      = in_valid[gi] && src_ready[gi];
      assign pop[gi]       = cdb_valid && (grant == 1'(gi));

      cdb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push[gi]),
        .wr_data (in_data[gi]),
        .pop     (pop[gi]),
        .flush   (flush),
        .full    (full[gi]),
        .empty   (empty[gi]),
        .head    (head_data[gi])
      );
    end
  endgenerate

  assign alu_ready = src_ready[0];
  assign lsb_ready = src_ready[1];

  // On a tie the source not granted most recently wins, bounding any wait
  // for a non-empty head to one cycle.
  always_comb begin
    grant = SRC_ALU;
    if (!empty[0] && !empty[1]) begin
      grant = ~last_grant_reg;
    end else if (!empty[1]) begin
      grant = SRC_LSB;
    end
  end

  assign cdb_valid   = rdy && !clear && !rst && (empty != 2'b11);
  assign grant_entry = head_data[grant];

  always_comb begin
    cdb_rob_id = '0;
    cdb_value  = '0;
    cdb_src    = SRC_ALU;
    if (cdb_valid) begin
      {cdb_rob_id, cdb_value} = grant_entry;
      cdb_src                 = grant;
    end
  end

  // cdb_valid already folds in rdy and clear, so the round-robin pointer
  // holds through stalls and flushes.
  always_comb begin
    last_grant_next = last_grant_reg;
    if (cdb_valid) last_grant_next = grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= SRC_LSB;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

endmodule
